// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler
// Round-robin scheduler that shares one parallel-in/serial-out shifter
// between NREQ requesters. A pending word is granted only while idle. It is
// loaded into the shift register and sent MSB-first with framing qualifiers.
// A programmable idle gap follows every frame.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   req_i        per-requester request, held high until acknowledged
//   data_i       word i at data_i[i*WIDTH +: WIDTH], stable while req_i[i] high
//   ack_o        one-cycle, one-hot pulse: word of requester i captured
//   ser_out_o    serial data bit, MSB first
//   ser_valid_o  high while ser_out_o carries a frame bit
//   ser_first_o  high on the first bit of each frame
//   ser_id_o     index of the requester owning the current frame
//   busy_o       high while shifting or in the inter-frame gap
module serial_tx_scheduler #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int GAP   = 1,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   data_i,
    output logic [NREQ-1:0]         ack_o,
    output logic                    ser_out_o,
    output logic                    ser_valid_o,
    output logic                    ser_first_o,
    output logic [IDW-1:0]          ser_id_o,
    output logic                    busy_o
);

    localparam int CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GapLast = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]      bitcnt_q, bitcnt_d;
    logic [GW-1:0]      gapcnt_q, gapcnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     ptr_q, ptr_d;

    logic [WIDTH-1:0]   words [NREQ];
    logic               found;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     cand;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign words[g] = data_i[g*WIDTH +: WIDTH];
    end

    // Round-robin search: start just after the last winner and wrap, so the
    // most recently served requester has the lowest priority next time.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state logic. Qualifiers are computed one cycle ahead so every
    // output comes straight from a flop. The shift register drains to zero
    // after WIDTH shifts, so ser_out is naturally low outside a frame.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        ack_d    = '0;
        valid_d  = valid_q;
        first_d  = 1'b0;
        id_d     = id_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (found) begin
                    shreg_d        = words[winner];
                    ack_d[winner]  = 1'b1;
                    id_d           = winner;
                    ptr_d          = winner;
                    bitcnt_d       = '0;
                    valid_d        = 1'b1;
                    first_d        = 1'b1;
                    busy_d         = 1'b1;
                    state_d        = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
                bitcnt_d = bitcnt_q + CW'(1);
                if (bitcnt_q == CW'(WIDTH - 1)) begin
                    valid_d  = 1'b0;
                    bitcnt_d = '0;
                    if (GAP > 0) begin
                        gapcnt_d = '0;
                        state_d  = S_GAP;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gapcnt_q == GW'(GapLast)) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gapcnt_d = gapcnt_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register. Reset aborts any frame in flight and re-arms the
    // pointer so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            ack_q    <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            id_q     <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= IDW'(NREQ - 1);
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            first_q  <= first_d;
            id_q     <= id_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
        end
    end

    assign ack_o       = ack_q;
    assign ser_out_o   = shreg_q[WIDTH-1];
    assign ser_valid_o = valid_q;
    assign ser_first_o = first_q;
    assign ser_id_o    = id_q;
    assign busy_o      = busy_q;

endmodule
